// File: rtl/sdm_pkg.sv
// Shared constants for the sigma-delta modulator: derived widths and the
// noise-shaping order encoding.
package sdm_pkg;

  typedef enum logic {
    ORDER_FIRST  = 1'b0,
    ORDER_SECOND = 1'b1
  } order_e;

  function automatic int calc_l(input int in_w, input int q_bits);
    return in_w - q_bits;
  endfunction

  function automatic int calc_tw(input int q_bits);
    return (1 << q_bits) - 1;
  endfunction

endpackage

// File: rtl/sdm_if.sv
// Sample-in / code-out bundle of the modulator core.
interface sdm_if #(
  parameter int IN_W   = 12,
  parameter int Q_BITS = 3
);
  localparam int TW = sdm_pkg::calc_tw(Q_BITS);

  logic              enable;
  logic              order_sel;
  logic [IN_W-1:0]   in_data;
  logic              in_valid;
  logic              in_ready;
  logic [Q_BITS-1:0] code_out;
  logic [TW-1:0]     therm_out;
  logic              sample_tick;
  logic              ovl_flag;
  logic [7:0]        ovl_count;
  logic              underrun;

  modport master (
    output enable, order_sel, in_data, in_valid,
    input  in_ready, code_out, therm_out, sample_tick, ovl_flag, ovl_count, underrun
  );

  modport slave (
    input  enable, order_sel, in_data, in_valid,
    output in_ready, code_out, therm_out, sample_tick, ovl_flag, ovl_count, underrun
  );
endinterface

// File: rtl/sdm_thermo_dec.sv
// Binary code to thermometer conversion: bit k is set when the code exceeds k.
module sdm_thermo_dec
  import sdm_pkg::*;
#(
  parameter int Q_BITS = 3
) (
  input  logic [Q_BITS-1:0]          i_code,
  output logic [calc_tw(Q_BITS)-1:0] o_therm
);
  localparam int TW = calc_tw(Q_BITS);

  for (genvar k = 0; k < TW; k++) begin : g_bit
    assign o_therm[k] = (i_code > Q_BITS'(k));
  end
endmodule

// File: rtl/sdm_core.sv
// Oversampling multi-bit sigma-delta modulator with selectable first/second
// order error feedback and a clamping quantizer.
module sdm_core
  import sdm_pkg::*;
#(
  parameter int IN_W   = 12,
  parameter int Q_BITS = 3,
  parameter int OSR    = 8
) (
  input logic  clck,
  input logic  rst,
  sdm_if.slave sif
);
  localparam int L  = calc_l(IN_W, Q_BITS);
  localparam int TW = calc_tw(Q_BITS);
  localparam int VW = IN_W + 3;
  localparam int PW = $clog2(OSR);
  localparam logic [PW-1:0] LAST = PW'(OSR - 1);
  localparam logic signed [VW-1:0] TW_S = VW'(TW);

  logic [PW-1:0]     r_phase;
  logic [IN_W-1:0]   r_u;
  logic [L-1:0]      r_e1;
  logic [L-1:0]      r_e2;
  order_e            r_order;
  logic [Q_BITS-1:0] r_code;
  logic [TW-1:0]     r_therm;
  logic              r_tick;
  logic              r_ovl;
  logic [7:0]        r_ovl_count;
  logic              r_underrun;

  logic                 w_last;
  logic                 w_ready;
  logic                 w_load;
  order_e               w_order_new;
  logic                 w_order_chg;
  logic signed [VW-1:0] w_u_s;
  logic signed [VW-1:0] w_e1_s;
  logic signed [VW-1:0] w_e2_s;
  logic signed [VW-1:0] w_v;
  logic signed [VW-1:0] w_raw;
  logic [Q_BITS-1:0]    w_code;
  logic                 w_clamp;
  logic [TW-1:0]        w_therm;

  assign w_last      = (r_phase == LAST);
  assign w_ready     = sif.enable & w_last;
  assign w_load      = w_ready & sif.in_valid;
  assign w_order_new = order_e'(sif.order_sel);
  assign w_order_chg = w_load && (w_order_new != r_order);

  assign w_u_s  = signed'({3'b000, r_u});
  assign w_e1_s = signed'({{(VW-L){1'b0}}, r_e1});
  assign w_e2_s = signed'({{(VW-L){1'b0}}, r_e2});

  // Error feedback: the residues left below the quantizer step are re-injected.
  always_comb begin
    w_v = w_u_s + w_e1_s;
    if (r_order == ORDER_SECOND) begin
      w_v = w_u_s + (w_e1_s <<< 1) - w_e2_s;
    end
  end

  assign w_raw = w_v >>> L;

  always_comb begin
    w_clamp = 1'b0;
    w_code  = w_raw[Q_BITS-1:0];
    if (w_raw[VW-1]) begin
      w_clamp = 1'b1;
      w_code  = '0;
    end else if (w_raw > TW_S) begin
      w_clamp = 1'b1;
      w_code  = Q_BITS'(TW);
    end
  end

  sdm_thermo_dec #(.Q_BITS(Q_BITS)) u_thermo (
    .i_code  (w_code),
    .o_therm (w_therm)
  );

  // The residue feedback keeps running through clamps; an order change restarts it from zero.
  always_ff @(posedge clck or posedge rst) begin
    if (rst) begin
      r_phase     <= '0;
      r_u         <= {1'b1, {(IN_W-1){1'b0}}};
      r_e1        <= '0;
      r_e2        <= '0;
      r_order     <= ORDER_FIRST;
      r_code      <= '0;
      r_therm     <= '0;
      r_tick      <= 1'b0;
      r_ovl       <= 1'b0;
      r_ovl_count <= '0;
      r_underrun  <= 1'b0;
    end else begin
      r_tick <= w_load;
      r_ovl  <= sif.enable & w_clamp;
      if (sif.enable) begin
        r_phase <= w_last ? '0 : r_phase + PW'(1);
        r_code  <= w_code;
        r_therm <= w_therm;
        if (w_clamp && (r_ovl_count != 8'hFF)) begin
          r_ovl_count <= r_ovl_count + 8'd1;
        end
        if (w_last && !sif.in_valid) begin
          r_underrun <= 1'b1;
        end
        if (w_load) begin
          r_u     <= {~sif.in_data[IN_W-1], sif.in_data[IN_W-2:0]};
          r_order <= w_order_new;
        end
        if (w_order_chg) begin
          r_e1 <= '0;
          r_e2 <= '0;
        end else begin
          r_e1 <= w_v[L-1:0];
          r_e2 <= r_e1;
        end
      end
    end
  end

  assign sif.in_ready    = w_ready;
  assign sif.code_out    = r_code;
  assign sif.therm_out   = r_therm;
  assign sif.sample_tick = r_tick;
  assign sif.ovl_flag    = r_ovl;
  assign sif.ovl_count   = r_ovl_count;
  assign sif.underrun    = r_underrun;
endmodule

// File: tb/tb_sdm_core.sv
// Self-checking bench for sdm_core: table-driven steady-state vectors plus
// hand-written corner sequences, all cycles scored against a queued model.
`timescale 1ns/1ps
module tb_sdm_core;
  import sdm_pkg::*;

  localparam int IN_W   = 8;
  localparam int Q_BITS = 3;
  localparam int OSR    = 4;
  localparam int L      = IN_W - Q_BITS;

  typedef struct {
    int code;
    int therm;
    int tick;
    int ovl;
    int cnt;
    int under;
  } exp_t;

  typedef struct {
    int data;
    bit order;
    int nCyc;
    int expSum;
    int expTherm;
  } vec_t;

  logic clck = 1'b0;
  logic rst;

  int nChecks = 0;
  int nErrors = 0;
  exp_t expQ[$];
  int lastReady;

  int mPhase, mU, mE1, mE2, mOrder, mCode, mTick, mOvl, mCnt, mUnder;

  always #5 clck = ~clck;

  sdm_if #(.IN_W(IN_W), .Q_BITS(Q_BITS)) sif ();

  sdm_core #(.IN_W(IN_W), .Q_BITS(Q_BITS), .OSR(OSR)) dut (
    .clck (clck),
    .rst  (rst),
    .sif  (sif)
  );

  // Compare one observed value against its expectation and keep the tallies.
  task automatic checkVal(input string name, input logic [31:0] act, input int exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPhase = 0; mU = 1 << (IN_W - 1); mE1 = 0; mE2 = 0; mOrder = 0;
    mCode = 0; mTick = 0; mOvl = 0; mCnt = 0; mUnder = 0;
    expQ.delete();
  endtask

  // Reference behaviour for one clock edge; pushes what the DUT should show after it.
  task automatic modelStep(input bit en, input bit valid, input int data, input bit osel);
    int v, raw, res, div, nE1, nE2;
    bit load, clamp;
    exp_t e;
    div = 1 << L;
    if (en) begin
      load = (mPhase == OSR - 1) && valid;
      v = (mOrder == 0) ? mU + mE1 : mU + 2 * mE1 - mE2;
      raw = (v >= 0) ? v / div : -((-v + div - 1) / div);
      res = v - raw * div;
      clamp = (raw < 0) || (raw > 7);
      mCode = (raw < 0) ? 0 : (raw > 7) ? 7 : raw;
      mOvl = clamp;
      if (clamp && mCnt < 255) mCnt++;
      if (mPhase == OSR - 1 && !valid) mUnder = 1;
      nE1 = res;
      nE2 = mE1;
      if (load) begin
        mU = data + (1 << (IN_W - 1));
        if (int'(osel) != mOrder) begin
          nE1 = 0;
          nE2 = 0;
        end
        mOrder = int'(osel);
      end
      mE1 = nE1;
      mE2 = nE2;
      mTick = load;
      mPhase = (mPhase + 1) % OSR;
    end else begin
      mTick = 0;
      mOvl = 0;
    end
    e.code = mCode; e.therm = (1 << mCode) - 1; e.tick = mTick;
    e.ovl = mOvl; e.cnt = mCnt; e.under = mUnder;
    expQ.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      nChecks++;
      nErrors++;
      $display("[TB] FAIL scoreboard: got 0 queued entries expected 1");
      return;
    end
    e = expQ.pop_front();
    checkVal("code_out", sif.code_out, e.code);
    checkVal("therm_out", sif.therm_out, e.therm);
    checkVal("sample_tick", sif.sample_tick, e.tick);
    checkVal("ovl_flag", sif.ovl_flag, e.ovl);
    checkVal("ovl_count", sif.ovl_count, e.cnt);
    checkVal("underrun", sif.underrun, e.under);
  endtask

  // Drive one cycle of inputs just after an edge, then score the following edge.
  task automatic applyStimulus(input bit en, input bit valid, input int data, input bit osel);
    sif.enable    = en;
    sif.in_valid  = valid;
    sif.in_data   = IN_W'(data);
    sif.order_sel = osel;
    #2;
    lastReady = int'(sif.in_ready);
    checkVal("in_ready", sif.in_ready, int'(en && (mPhase == OSR - 1)));
    modelStep(en, valid, data, osel);
    @(posedge clck);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    sif.enable = 1'b0; sif.in_valid = 1'b0; sif.in_data = '0; sif.order_sel = 1'b0;
    rst = 1'b1;
    @(posedge clck);
    #1;
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    vec_t vecs[8];
    int expB[8];
    int sum, ticks;

    vecs[0] = '{0,    1'b0, 16, 64,  15};
    vecs[1] = '{16,   1'b0, 16, 72,  -1};
    vecs[2] = '{8,    1'b0, 16, 68,  -1};
    vecs[3] = '{-64,  1'b0, 16, 32,  3};
    vecs[4] = '{-128, 1'b0, 16, 0,   0};
    vecs[5] = '{127,  1'b0, 16, 112, 127};
    vecs[6] = '{16,   1'b1, 64, 288, -1};
    vecs[7] = '{-128, 1'b1, 16, 0,   0};
    expB = '{4, 5, 4, 5, 4, 5, 5, 4};

    sif.enable = 1'b1; sif.in_valid = 1'b0; sif.in_data = '0; sif.order_sel = 1'b0;
    rst = 1'b1;
    @(posedge clck);
    #1;
    checkVal("reset code_out", sif.code_out, 0);
    checkVal("reset therm_out", sif.therm_out, 0);
    checkVal("reset sample_tick", sif.sample_tick, 0);
    checkVal("reset ovl_flag", sif.ovl_flag, 0);
    checkVal("reset ovl_count", sif.ovl_count, 0);
    checkVal("reset underrun", sif.underrun, 0);
    checkVal("reset in_ready", sif.in_ready, 0);
    rst = 1'b0;
    modelReset();

    // Steady-state table: warm up 8 cycles, then sum codes over the window.
    for (int i = 0; i < 8; i++) begin
      doReset();
      sum = 0;
      for (int c = 0; c < 8 + vecs[i].nCyc; c++) begin
        applyStimulus(1'b1, 1'b1, vecs[i].data, vecs[i].order);
        if (c >= 8) begin
          sum += int'(sif.code_out);
          if (vecs[i].expTherm >= 0) checkVal("table therm", sif.therm_out, vecs[i].expTherm);
        end
      end
      checkVal("table code sum", sum, vecs[i].expSum);
    end

    // Full-scale positive input: first code 7 unclamped, then clamps saturate the counter.
    doReset();
    for (int c = 0; c < 320; c++) begin
      applyStimulus(1'b1, 1'b1, 127, 1'b0);
      if (c == 4) begin
        checkVal("fullscale first code", sif.code_out, 7);
        checkVal("fullscale first ovl", sif.ovl_flag, 0);
      end
      if (c == 5) begin
        checkVal("fullscale clamp ovl", sif.ovl_flag, 1);
        checkVal("fullscale clamp count", sif.ovl_count, 1);
      end
    end
    checkVal("ovl_count saturated", sif.ovl_count, 255);

    // One empty slot: underrun sticks, old sample reused, ticks only on loads.
    doReset();
    ticks = 0;
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b1, !(c >= 4 && c <= 7), 16, 1'b0);
      ticks += int'(sif.sample_tick);
      if (c == 6) checkVal("underrun before slot", sif.underrun, 0);
      if (c == 7) checkVal("underrun after slot", sif.underrun, 1);
      if (c == 8) checkVal("reused sample code a", sif.code_out, 4);
      if (c == 9) checkVal("reused sample code b", sif.code_out, 5);
    end
    checkVal("sample_tick count", ticks, 2);
    checkVal("underrun sticky", sif.underrun, 1);

    // order_sel toggled mid-sample only takes effect at the next load.
    doReset();
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b1, 1'b1, 16, c >= 5);
      if (c >= 4) checkVal("order toggle code", sif.code_out, expB[c-4]);
    end

    // Asynchronous reset at phase 2, then enable freeze.
    doReset();
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b1, c >= 4, 127, 1'b0);
    end
    checkVal("pre-reset code", sif.code_out, 7);
    rst = 1'b1;
    #1;
    checkVal("async reset code_out", sif.code_out, 0);
    checkVal("async reset therm_out", sif.therm_out, 0);
    checkVal("async reset ovl_flag", sif.ovl_flag, 0);
    checkVal("async reset ovl_count", sif.ovl_count, 0);
    checkVal("async reset underrun", sif.underrun, 0);
    modelReset();
    @(posedge clck);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b1, 1'b1, 0, 1'b0);
      if (c < OSR - 1) checkVal("post-reset ready low", lastReady, 0);
      if (c == OSR - 1) checkVal("post-reset first ready", lastReady, 1);
    end
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0, 1'b1, -128, 1'b1);
      checkVal("freeze in_ready", lastReady, 0);
      checkVal("freeze code", sif.code_out, 4);
      checkVal("freeze therm", sif.therm_out, 15);
      checkVal("freeze tick", sif.sample_tick, 0);
    end
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b1, 1'b1, -128, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
